// File: rtl/prog_sequencer.sv
// Run-control sequencer: launches NUM_PROGS programs in series, holds fetch for
// HOLD_CYC cycles per program, times each run and applies a watchdog limit.
module prog_sequencer #(
   parameter int                          PC_W        = 10,
   parameter int                          NUM_PROGS   = 3,
   parameter logic [NUM_PROGS*PC_W-1:0]   START_ADDRS = {10'd512, 10'd256, 10'd0},
   parameter int                          HOLD_CYC    = 2,
   parameter int                          TIMEOUT     = 4096
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Go,
   input  logic            Done,
   output logic            Load,
   output logic [PC_W-1:0] TargetAddr,
   output logic            Start,
   output logic [1:0]      ProgIdx,
   output logic [15:0]     CycleCount,
   output logic            CountValid,
   output logic            TimedOut,
   output logic            AllDone
);

   typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, REPORT, FINISH} state_t;

   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
   localparam logic [15:0] RUN_LAST  = 16'(TIMEOUT - 1);
   localparam logic [15:0] RUN_LIMIT = 16'(TIMEOUT);
   localparam logic [1:0]  LAST_IDX  = 2'(NUM_PROGS - 1);

   state_t      state, state_nxt;
   logic [1:0]  idx_nxt;
   logic [15:0] hold_cnt;
   logic [15:0] run_cnt;

   function automatic logic [PC_W-1:0] start_addr(input logic [1:0] idx);
      return START_ADDRS[int'(idx)*PC_W +: PC_W];
   endfunction

   always_comb begin
      state_nxt = state;
      idx_nxt   = ProgIdx;
      case (state)
         IDLE, FINISH: begin
            if (Go) begin
               state_nxt = LOAD;
               idx_nxt   = 2'd0;
            end
         end
         LOAD:    state_nxt = HOLD;
         HOLD:    if (hold_cnt == HOLD_LAST) state_nxt = RUN;
         RUN:     if (Done || run_cnt == RUN_LAST) state_nxt = REPORT;
         REPORT: begin
            if (ProgIdx == LAST_IDX) begin
               state_nxt = FINISH;
            end else begin
               state_nxt = LOAD;
               idx_nxt   = ProgIdx + 2'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state      <= IDLE;
         ProgIdx    <= 2'd0;
         TargetAddr <= '0;
         CycleCount <= 16'd0;
         TimedOut   <= 1'b0;
         hold_cnt   <= 16'd0;
         run_cnt    <= 16'd0;
      end else begin
         state   <= state_nxt;
         ProgIdx <= idx_nxt;
         if (state_nxt == LOAD)
            TargetAddr <= start_addr(idx_nxt);
         if ((state == IDLE || state == FINISH) && Go)
            TimedOut <= 1'b0;
         if (state == LOAD)
            hold_cnt <= 16'd0;
         else if (state == HOLD)
            hold_cnt <= hold_cnt + 16'd1;
         if (state == HOLD)
            run_cnt <= 16'd0;
         else if (state == RUN && !Done)
            run_cnt <= run_cnt + 16'd1;
         // Done takes priority over the watchdog when both land on the same cycle
         if (state == RUN) begin
            if (Done) begin
               CycleCount <= run_cnt;
            end else if (run_cnt == RUN_LAST) begin
               CycleCount <= RUN_LIMIT;
               TimedOut   <= 1'b1;
            end
         end
      end
   end

   assign Load       = (state == LOAD);
   assign Start      = (state == IDLE) || (state == HOLD);
   assign CountValid = (state == REPORT);
   assign AllDone    = (state == FINISH);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: per-cycle expectation table for whole series
// on a default instance and a TIMEOUT=8 instance, plus hand-written reset/restart cases.
module tb_prog_sequencer;

   localparam int HOLD = 2;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic Reset;
   logic go_a, done_a, go_b, done_b;
   logic load_a, start_a, cv_a, to_a, all_a;
   logic load_b, start_b, cv_b, to_b, all_b;
   logic [9:0]  tgt_a, tgt_b;
   logic [1:0]  idx_a, idx_b;
   logic [15:0] cc_a, cc_b;

   prog_sequencer dut_a (
      .Clk(Clk), .Reset(Reset), .Go(go_a), .Done(done_a), .Load(load_a),
      .TargetAddr(tgt_a), .Start(start_a), .ProgIdx(idx_a), .CycleCount(cc_a),
      .CountValid(cv_a), .TimedOut(to_a), .AllDone(all_a));

   prog_sequencer #(.TIMEOUT(8)) dut_b (
      .Clk(Clk), .Reset(Reset), .Go(go_b), .Done(done_b), .Load(load_b),
      .TargetAddr(tgt_b), .Start(start_b), .ProgIdx(idx_b), .CycleCount(cc_b),
      .CountValid(cv_b), .TimedOut(to_b), .AllDone(all_b));

   typedef struct packed {
      logic        load;
      logic        start;
      logic [9:0]  addr;
      logic [1:0]  idx;
      logic        cv;
      logic [15:0] cc;
      logic        to;
      logic        alld;
   } obs_t;

   typedef struct {
      bit   sel;
      bit   go;
      bit   done;
      obs_t exp;
   } vec_t;

   vec_t        tbl[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [9:0]  e_addr;
   logic [1:0]  e_idx;
   logic [15:0] e_cc;
   logic        e_to;
   bit          cur_sel;

   function automatic obs_t mk(input logic load, input logic start, input logic [9:0] addr,
                               input logic [1:0] idx, input logic cv, input logic [15:0] cc,
                               input logic to, input logic alld);
      obs_t o;
      o.load = load; o.start = start; o.addr = addr; o.idx = idx;
      o.cv = cv; o.cc = cc; o.to = to; o.alld = alld;
      return o;
   endfunction

   function automatic obs_t get_obs(input bit sel);
      if (sel)
         return mk(load_b, start_b, tgt_b, idx_b, cv_b, cc_b, to_b, all_b);
      return mk(load_a, start_a, tgt_a, idx_a, cv_a, cc_a, to_a, all_a);
   endfunction

   function automatic logic [9:0] addr_of(input int p);
      case (p)
         0:       return 10'd0;
         1:       return 10'd256;
         default: return 10'd512;
      endcase
   endfunction

   task automatic chk(input string name, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got load=%b start=%b addr=%0d idx=%0d cv=%b cc=%0d to=%b all=%b, want load=%b start=%b addr=%0d idx=%0d cv=%b cc=%0d to=%b all=%b",
                  name, act.load, act.start, act.addr, act.idx, act.cv, act.cc, act.to, act.alld,
                  exp.load, exp.start, exp.addr, exp.idx, exp.cv, exp.cc, exp.to, exp.alld);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // One row = inputs held during a cycle, outputs expected just after its closing edge.
   task automatic push(input bit go, input bit done, input bit load, input bit start,
                       input bit cv, input bit alld);
      vec_t v;
      v.sel  = cur_sel;
      v.go   = go;
      v.done = done;
      v.exp  = mk(load, start, e_addr, e_idx, cv, e_cc, e_to, alld);
      tbl.push_back(v);
   endtask

   // n RUN cycles without Done, then either Done or the watchdog expiring.
   task automatic prog(input int p, input bit from_idle, input int n, input bit tmo,
                       input bit spur_done, input bit spur_go, input int tlim);
      e_idx  = 2'(p);
      e_addr = addr_of(p);
      if (from_idle) e_to = 1'b0;
      push(from_idle, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < HOLD; i++) push(1'b0, spur_done, 1'b0, 1'b1, 1'b0, 1'b0);
      push(1'b0, spur_done, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) push(spur_go && (i == 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (tmo) begin
         e_cc = 16'(tlim);
         e_to = 1'b1;
         push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
         e_cc = 16'(n);
         push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic finish_row(input bit done);
      push(1'b0, done, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      obs_t rst_val;
      rst_val = mk(1'b0, 1'b1, 10'd0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0);

      // Nominal series, spurious Done in LOAD/HOLD of prog 0, spurious Go in RUN of prog 1
      cur_sel = 1'b0; e_addr = '0; e_idx = '0; e_cc = '0; e_to = 1'b0;
      prog(0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 4096);
      prog(1, 1'b0, 20, 1'b0, 1'b0, 1'b1, 4096);
      prog(2, 1'b0, 5,  1'b0, 1'b0, 1'b0, 4096);
      finish_row(1'b0);
      finish_row(1'b1);
      finish_row(1'b0);

      // TIMEOUT=8: prog 1 times out, flag sticks; then restart with Done on the 8th RUN cycle
      cur_sel = 1'b1; e_addr = '0; e_idx = '0; e_cc = '0; e_to = 1'b0;
      prog(0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 8);
      prog(1, 1'b0, 7, 1'b1, 1'b0, 1'b0, 8);
      prog(2, 1'b0, 4, 1'b0, 1'b0, 1'b0, 8);
      finish_row(1'b0);
      prog(0, 1'b1, 7, 1'b0, 1'b0, 1'b0, 8);
      prog(1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8);
      prog(2, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8);
      finish_row(1'b0);

      // Reset held with Go and Done asserted
      Reset = 1'b0; go_a = 1'b1; done_a = 1'b1; go_b = 1'b1; done_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("reset_a%0d", i), get_obs(1'b0), rst_val);
         chk($sformatf("reset_b%0d", i), get_obs(1'b1), rst_val);
      end
      Reset = 1'b1; go_a = 1'b0; done_a = 1'b0; go_b = 1'b0; done_b = 1'b0;
      step();
      chk("idle_after_reset", get_obs(1'b0), rst_val);

      for (int i = 0; i < tbl.size(); i++) begin
         go_a   = tbl[i].sel ? 1'b0 : tbl[i].go;
         done_a = tbl[i].sel ? 1'b0 : tbl[i].done;
         go_b   = tbl[i].sel ? tbl[i].go   : 1'b0;
         done_b = tbl[i].sel ? tbl[i].done : 1'b0;
         step();
         chk($sformatf("row%0d_%s", i, tbl[i].sel ? "b" : "a"), get_obs(tbl[i].sel), tbl[i].exp);
      end
      go_a = 1'b0; done_a = 1'b0; go_b = 1'b0; done_b = 1'b0;

      // Restart from FINISH, Done in first RUN cycle, then reset during HOLD of prog 1
      go_a = 1'b1;
      step();
      chk("restart_load", get_obs(1'b0), mk(1'b1, 1'b0, 10'd0, 2'd0, 1'b0, 16'd5, 1'b0, 1'b0));
      go_a = 1'b0;
      step(); step(); step();
      chk("restart_run", get_obs(1'b0), mk(1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 16'd5, 1'b0, 1'b0));
      done_a = 1'b1;
      step();
      chk("done_first_cycle", get_obs(1'b0), mk(1'b0, 1'b0, 10'd0, 2'd0, 1'b1, 16'd0, 1'b0, 1'b0));
      done_a = 1'b0;
      step();
      chk("prog1_load", get_obs(1'b0), mk(1'b1, 1'b0, 10'd256, 2'd1, 1'b0, 16'd0, 1'b0, 1'b0));
      step();
      chk("prog1_hold", get_obs(1'b0), mk(1'b0, 1'b1, 10'd256, 2'd1, 1'b0, 16'd0, 1'b0, 1'b0));
      Reset = 1'b0;
      step();
      chk("midrun_reset", get_obs(1'b0), rst_val);
      chk("midrun_reset_b", get_obs(1'b1), rst_val);
      Reset = 1'b1;
      step();
      chk("idle_after_midrun", get_obs(1'b0), rst_val);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run-control block that launches the processor's programs in series. It loads each program's start address into the instruction fetch unit, holds fetch via `Start` for a fixed number of cycles, and then waits for the core's `Done`. It measures each program's run length and enforces a watchdog timeout. It sits between the test harness (`Go`) and the fetch/PC logic (`Start`, `Load`, `TargetAddr`).

## Interface
- `PC_W`, 10: program counter / address width.
- `NUM_PROGS`, 3: number of programs run per series (1..4).
- `START_ADDRS`, {10'd512, 10'd256, 10'd0}: packed NUM_PROGS×PC_W start addresses; program i uses slice [i*PC_W +: PC_W].
- `HOLD_CYC`, 2: cycles `Start` is held high per program (≥1).
- `TIMEOUT`, 4096: watchdog limit in RUN cycles (1..65535).

Ports:
- `Clk`, input, 1: sole clock; all state changes on posedge only.
- `Reset`, input, 1: synchronous, active-low reset (0 = reset).
- `Go`, input, 1: begin a series; sampled only in IDLE or FINISH.
- `Done`, input, 1: core reports the current program finished; sampled only in RUN.
- `Load`, output, 1: one-cycle pulse; fetch loads `TargetAddr` into its PC.
- `TargetAddr`, output, PC_W: start address of the current program.
- `Start`, output, 1: hold fetch; driven to the fetch unit's `Start`.
- `ProgIdx`, output, 2: index of the current or last program.
- `CycleCount`, output, 16: run length of the last completed program.
- `CountValid`, output, 1: one-cycle pulse when `CycleCount` updates.
- `TimedOut`, output, 1: sticky; set if any program in the series hit `TIMEOUT`.
- `AllDone`, output, 1: series complete; level.

## Operation
- FSM states: IDLE, LOAD, HOLD, RUN, REPORT, FINISH.
- IDLE: all pulses low. `Go`=1 → LOAD with `ProgIdx`=0, `TimedOut` cleared.
- LOAD (1 cycle): `Load`=1, `TargetAddr`=START_ADDRS[ProgIdx]. Next state is HOLD; hold counter loads 0.
- HOLD: `Start`=1. After HOLD_CYC cycles in HOLD, go to RUN; run counter loads 0.
- RUN: `Start`=0. The run counter increments every cycle that `Done`=0.
  - `Done`=1 → REPORT and latch count (the number of RUN cycles before `Done`).
  - Counter reaching TIMEOUT−1 with `Done`=0 → REPORT, latch TIMEOUT, set `TimedOut`.
  - `Done` and timeout in the same cycle: `Done` wins, and `TimedOut` is not set.
- REPORT (1 cycle): `CountValid`=1 and `CycleCount` shows the latched value.
  - If `ProgIdx`=NUM_PROGS−1, go to FINISH.
  - Otherwise increment `ProgIdx` and go to LOAD.
- FINISH: `AllDone`=1 and `ProgIdx` holds the last index. `Go`=1 → LOAD with `ProgIdx`=0, `AllDone`→0, `TimedOut` cleared.
- `Done` is ignored outside RUN. `Go` is ignored outside IDLE/FINISH.
- `TargetAddr` is registered and holds its value between loads.
- `CycleCount` holds until the next REPORT.

## Timing
- Reset values (`Reset`=0 at a posedge):
  - State = IDLE.
  - `Load`=0, `Start`=1, `TargetAddr`=0, `ProgIdx`=0, `CycleCount`=0, `CountValid`=0, `TimedOut`=0, `AllDone`=0.
- `Start`=1 in IDLE and at reset, so fetch stays held until a program is launched.
- Reset mid-operation wins over every other condition and returns to IDLE the next cycle. No partial report is made.
- All outputs are registered and decoded from state; there are no combinational input→output paths.
- `Go` sampled at edge k → `Load`=1 during cycle k+1.
- `Start` is high for exactly HOLD_CYC cycles after `Load`, then low in the first RUN cycle.
- `Done` sampled at edge m of RUN → `CountValid`=1 during cycle m+1.
- Next program's `Load` occurs in cycle m+2.
- Per-program overhead outside RUN is 1 (LOAD) + HOLD_CYC + 1 (REPORT) cycles.

## Test plan
- Reset check: hold `Reset`=0 for 3 cycles with `Go`=1 and `Done`=1 → all outputs at reset values, state IDLE, `Start`=1.
- Nominal series, default parameters:
  - Stimulus: `Go` pulse; `Done` asserted after 10, 20 and 5 RUN cycles.
  - Required: `TargetAddr` = 0, 256, 512 in order, each with one `Load` pulse and `Start` high for 2 cycles.
  - Required: `CycleCount` = 10, 20, 5 with three `CountValid` pulses, then `AllDone`=1 and `TimedOut`=0.
- Timeout, TIMEOUT=8: program 1 never asserts `Done` → `CountValid` with `CycleCount`=8, `TimedOut`=1, sequencing continues to program 2 and `TimedOut` stays set.
- Simultaneous `Done` and timeout (TIMEOUT=8): `Done` in the 8th RUN cycle → `CycleCount`=7 and `TimedOut`=0.
- Spurious and ignored inputs:
  - `Done` pulsed during LOAD/HOLD → no state change.
  - `Go` pulsed during RUN → no restart, `ProgIdx` unchanged.
- Restart and mid-run reset:
  - `Go` in FINISH → `AllDone`=0, `TimedOut`=0, `TargetAddr`=0.
  - `Reset`=0 during HOLD of program 1 → IDLE next cycle, `ProgIdx`=0, `Start`=1.
